// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a fixed exponent mod 2^255-19.
// Drives one external Montgomery multiplier through a start/finished handshake.
`timescale 1ns/1ps
module mont_exp_ctrl #(
   parameter int               WIDTH   = 256,
   parameter logic [WIDTH-1:0] EXP     = {1'b0, {250{1'b1}}, 5'b01011},
   parameter int               EXP_MSB = 254
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   output logic             o_busy,
   output logic             o_finished,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_mul_a,
   output logic [WIDTH-1:0] o_mul_b,
   output logic             o_mul_start,
   input  logic [WIDTH-1:0] i_mul_result,
   input  logic             i_mul_finished
);

   localparam int            KW     = $clog2(WIDTH);
   localparam logic [KW-1:0] K_INIT = (EXP_MSB > 0) ? KW'(EXP_MSB - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SQR_ISSUE = 3'd1,
      S_SQR_WAIT  = 3'd2,
      S_MUL_ISSUE = 3'd3,
      S_MUL_WAIT  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_base;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_mul_a;
   logic [WIDTH-1:0] r_mul_b;
   logic [WIDTH-1:0] w_acc_next;
   logic [KW-1:0]    r_k;
   logic             r_armed;
   logic             w_accept;
   logic             w_in_wait;
   logic             w_mul_done;
   logic             w_exp_bit;
   logic             w_k_zero;
   logic             w_k_dec;

   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_in_wait  = (r_state == S_SQR_WAIT) || (r_state == S_MUL_WAIT);
   // r_armed is low in the first WAIT cycle so a stale finished level is not taken.
   assign w_mul_done = w_in_wait && r_armed && i_mul_finished;
   assign w_exp_bit  = EXP[r_k];
   assign w_k_zero   = (r_k == '0);
   assign w_k_dec    = w_mul_done && !w_k_zero &&
                       (((r_state == S_SQR_WAIT) && !w_exp_bit) || (r_state == S_MUL_WAIT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = (EXP_MSB == 0) ? S_DONE : S_SQR_ISSUE;
            end
         end
         S_SQR_ISSUE: w_state_next = S_SQR_WAIT;
         S_SQR_WAIT: begin
            if (w_mul_done) begin
               if (w_exp_bit)     w_state_next = S_MUL_ISSUE;
               else if (w_k_zero) w_state_next = S_DONE;
               else               w_state_next = S_SQR_ISSUE;
            end
         end
         S_MUL_ISSUE: w_state_next = S_MUL_WAIT;
         S_MUL_WAIT: begin
            if (w_mul_done) begin
               w_state_next = w_k_zero ? S_DONE : S_SQR_ISSUE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = 1'b0;
      o_finished  = 1'b0;
      o_mul_start = 1'b0;
      case (r_state)
         S_SQR_ISSUE, S_MUL_ISSUE: begin
            o_busy      = 1'b1;
            o_mul_start = 1'b1;
         end
         S_SQR_WAIT, S_MUL_WAIT: o_busy = 1'b1;
         S_DONE: begin
            o_busy     = 1'b1;
            o_finished = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_acc_next = r_acc;
      if (w_accept) begin
         w_acc_next = i_a;
      end else if (w_mul_done) begin
         w_acc_next = i_mul_result;
      end
   end

   // Operand registers load on entry to an ISSUE state and hold through WAIT.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= '0;
         r_base   <= '0;
         r_result <= '0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
         r_k      <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_acc   <= w_acc_next;
         r_armed <= w_in_wait;
         if (w_accept) begin
            r_base <= i_a;
            r_k    <= K_INIT;
         end else if (w_k_dec) begin
            r_k <= r_k - KW'(1);
         end
         if (w_state_next == S_SQR_ISSUE) begin
            r_mul_a <= w_acc_next;
            r_mul_b <= w_acc_next;
         end else if (w_state_next == S_MUL_ISSUE) begin
            r_mul_a <= w_acc_next;
            r_mul_b <= r_base;
         end
         if (w_state_next == S_DONE) begin
            r_result <= w_acc_next;
         end
      end
   end

   assign o_result = r_result;
   assign o_mul_a  = r_mul_a;
   assign o_mul_b  = r_mul_b;

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Sequencer that drives one shared numberMul Montgomery multiplier to compute a fixed-exponent modular power, Montgomery-domain in and out, modulus p = 2^255-19.
- Default exponent p-2 gives the field inverse used in the ECC point-arithmetic layer. Exponent (p+3)/8 gives the square-root candidate.
- Left-to-right square-and-multiply.
- The multiplier is external to this block and is reached through a start/finished port pair.

Parameters:
- WIDTH, 256: operand/result width.
- EXP, 2^255-21 (p-2): fixed exponent, WIDTH bits.
- EXP_MSB, 254: index of the most significant set bit of EXP.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request pulse. Accepted only in IDLE.
- i_a  in  WIDTH  base in Montgomery form (a*2^256 mod p). Sampled on the accepted i_start cycle.
- o_busy  out  1  high from the cycle after acceptance through the DONE cycle.
- o_finished  out  1  one-cycle pulse; o_result valid that cycle.
- o_result  out  WIDTH  a^EXP in Montgomery form. Held until the next accepted start.
- o_mul_a  out  WIDTH  multiplier operand A.
- o_mul_b  out  WIDTH  multiplier operand B.
- o_mul_start  out  1  one-cycle multiplier start pulse.
- i_mul_result  in  WIDTH  multiplier result.
- i_mul_finished  in  1  multiplier done, level or pulse.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. o_busy, o_finished, o_mul_start = 0. o_result, o_mul_a, o_mul_b, acc, base, bit index all = 0.
- Reset asserted mid-operation abandons the exponentiation immediately. A multiplier result arriving after reset release is ignored, because IDLE never samples i_mul_finished.
- IDLE: when i_start=1, latch base=i_a and acc=i_a, set bit index k=EXP_MSB-1, then go to SQR_ISSUE. If EXP_MSB==0, go to DONE instead.
- i_start while not IDLE: ignored, no effect on any state.
- SQR_ISSUE: o_mul_a=o_mul_b=acc, o_mul_start=1 for exactly this cycle, next state SQR_WAIT.
- SQR_WAIT:
  - i_mul_finished is ignored on the first WAIT cycle (the cycle after the start pulse), so a stale level from the previous operation is not taken.
  - From the second WAIT cycle onward, on i_mul_finished=1 set acc=i_mul_result.
  - Then go to MUL_ISSUE if EXP[k]=1. Otherwise, if k==0 go to DONE, else k=k-1 and go to SQR_ISSUE.
- MUL_ISSUE: o_mul_a=acc, o_mul_b=base, o_mul_start=1 for exactly this cycle, next state MUL_WAIT.
- MUL_WAIT: same first-cycle masking rule as SQR_WAIT. On finished set acc=i_mul_result; then go to DONE if k==0, else k=k-1 and go to SQR_ISSUE.
- DONE (one cycle): o_result=acc, o_finished=1, o_busy=1. Next state IDLE, where o_busy=0.
- A new i_start is accepted in the cycle immediately after DONE.
- o_mul_a and o_mul_b hold their values from ISSUE through the whole WAIT state.
- Operation count for the default EXP: 254 squarings plus 252 multiplies = 506 o_mul_start pulses.
  - EXP bits 254..5 = 1, bit4 = 0, bit3 = 1, bit2 = 0, bit1 = 1, bit0 = 1.
- No zero short-circuit: base 0 still runs all 506 operations and yields 0.
- No arithmetic in this block; operands pass straight through and are never reduced here.
- Latency with a multiplier of fixed latency L (finished L cycles after start, L>=2): acceptance to o_finished = 1 + 506*(L+1) cycles.

Test Plan:
- Reset: assert i_rst_n=0 mid-run (e.g. at op 100), release, then i_start with i_a=38 -> all outputs 0 during reset; the new run completes with o_result=38 (Montgomery 1, self-inverse) and exactly 506 start pulses.
- Inverse of 2: i_a=76 (Montgomery 2) -> o_result=19, which is Montgomery (p+1)/2. Checked in the same cycle o_finished=1.
- Inverse of -1: i_a=p-38 -> o_result=p-38.
- Zero: i_a=0 -> o_result=0, 506 pulses, o_finished exactly one cycle.
- Handshake stress:
  - Multiplier model with random latency 2..20 that holds i_mul_finished high as a level until the next start -> no double-consumed results; result is correct for 1000 random bases.
  - The real numberMul is used as the bench golden model, with expected value a*inv = Montgomery 1 = 38.
- i_start pulsed at op 10 and in the DONE cycle -> both ignored. i_start in the cycle after DONE -> accepted, o_busy=1 on the next cycle.
